// File: rtl/data_req_win.sv
// Read-address generator for a sliding KxK convolution window over a WxH feature map.
// Walks K lines of W words per window, moving down by S rows per window, then pulses o_done.
module data_req_win #(
   parameter int ADDR_WIDTH        = 32,
   parameter int KERNEL_SIZE_WIDTH = 4,
   parameter int DIM_WIDTH         = 16,
   parameter int STRIDE_WIDTH      = 4,
   parameter int REG_WIDTH         = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_req,
   input  logic                  i_stall,
   input  logic [ADDR_WIDTH-1:0] i_conf_baseaddr,
   input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
   input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
   input  logic [REG_WIDTH-1:0]  i_conf_stride,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_rden,
   output logic                  o_busy,
   output logic                  o_line_end,
   output logic                  o_window_end,
   output logic                  o_done,
   output logic                  o_err,
   output logic [REG_WIDTH-1:0]  dbg_datareq_row_cnt,
   output logic [REG_WIDTH-1:0]  dbg_datareq_addr_reg
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]                   state;
   logic [DIM_WIDTH-1:0]         w_lat, h_lat, col_cnt, top_row;
   logic [KERNEL_SIZE_WIDTH-1:0] k_lat, k_cnt;
   logic [STRIDE_WIDTH-1:0]      s_lat;
   logic [ADDR_WIDTH-1:0]        base_lat, addr_reg, line_base, win_base, step_win;
   logic [DIM_WIDTH:0]           next_bottom;
   logic                         cfg_bad, line_last, k_last;

   assign o_rden  = (state == ST_RUN) & i_req & ~i_stall;
   assign o_addr  = addr_reg;
   assign o_busy  = (state == ST_CHECK) | (state == ST_RUN);

   assign dbg_datareq_row_cnt  = REG_WIDTH'({top_row, k_cnt});
   assign dbg_datareq_addr_reg = REG_WIDTH'(addr_reg);

   assign cfg_bad   = (k_lat == '0) | (s_lat == '0) | (w_lat == '0) |
                      (DIM_WIDTH'(k_lat) > h_lat);
   assign line_last = (col_cnt == w_lat - DIM_WIDTH'(1));
   assign k_last    = (k_cnt == k_lat - KERNEL_SIZE_WIDTH'(1));
   // One bit wider than the dimensions so the last-window test cannot overflow.
   assign next_bottom = {1'b0, top_row} + (DIM_WIDTH+1)'(s_lat) + (DIM_WIDTH+1)'(k_lat);

   always_ff @(posedge clk) begin
      if (rst || i_abort) begin
         state        <= ST_IDLE;
         addr_reg     <= '0;
         line_base    <= '0;
         win_base     <= '0;
         col_cnt      <= '0;
         k_cnt        <= '0;
         top_row      <= '0;
         o_line_end   <= 1'b0;
         o_window_end <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         if (rst) begin
            step_win <= '0;
            w_lat    <= '0;
            h_lat    <= '0;
            k_lat    <= '0;
            s_lat    <= '0;
            base_lat <= '0;
         end
      end else begin
         o_line_end   <= 1'b0;
         o_window_end <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  w_lat    <= i_conf_inputshape[DIM_WIDTH-1:0];
                  h_lat    <= i_conf_inputshape[2*DIM_WIDTH-1:DIM_WIDTH];
                  k_lat    <= i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0];
                  s_lat    <= i_conf_stride[STRIDE_WIDTH-1:0];
                  base_lat <= i_conf_baseaddr;
                  state    <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               step_win  <= ADDR_WIDTH'(s_lat) * ADDR_WIDTH'(w_lat);
               line_base <= base_lat;
               win_base  <= base_lat;
               addr_reg  <= base_lat;
               col_cnt   <= '0;
               k_cnt     <= '0;
               top_row   <= '0;
               if (cfg_bad) begin
                  o_err <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (o_rden) begin
                  if (!line_last) begin
                     col_cnt  <= col_cnt + DIM_WIDTH'(1);
                     addr_reg <= addr_reg + ADDR_WIDTH'(1);
                  end else begin
                     col_cnt    <= '0;
                     o_line_end <= 1'b1;
                     if (!k_last) begin
                        k_cnt     <= k_cnt + KERNEL_SIZE_WIDTH'(1);
                        line_base <= line_base + ADDR_WIDTH'(w_lat);
                        addr_reg  <= line_base + ADDR_WIDTH'(w_lat);
                     end else begin
                        k_cnt        <= '0;
                        o_window_end <= 1'b1;
                        if (next_bottom > {1'b0, h_lat}) begin
                           o_done <= 1'b1;
                           state  <= ST_DONE;
                        end else begin
                           top_row   <= top_row + DIM_WIDTH'(s_lat);
                           win_base  <= win_base + step_win;
                           line_base <= win_base + step_win;
                           addr_reg  <= win_base + step_win;
                        end
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_req_win.sv
// Directed bench for data_req_win: table of frame configs with hand-computed totals,
// plus stall, abort, mid-run start and mid-run reset sequences.
module tb_data_req_win;

   logic        clk = 1'b0;
   logic        rst, i_start, i_abort, i_req, i_stall;
   logic [31:0] i_conf_baseaddr, i_conf_inputshape, i_conf_kernelshape, i_conf_stride;
   logic [31:0] o_addr;
   logic        o_rden, o_busy, o_line_end, o_window_end, o_done, o_err;
   logic [31:0] dbg_datareq_row_cnt, dbg_datareq_addr_reg;

   data_req_win #(
      .ADDR_WIDTH(32), .KERNEL_SIZE_WIDTH(4), .DIM_WIDTH(16), .STRIDE_WIDTH(4), .REG_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_req(i_req),
      .i_stall(i_stall), .i_conf_baseaddr(i_conf_baseaddr),
      .i_conf_inputshape(i_conf_inputshape), .i_conf_kernelshape(i_conf_kernelshape),
      .i_conf_stride(i_conf_stride), .o_addr(o_addr), .o_rden(o_rden), .o_busy(o_busy),
      .o_line_end(o_line_end), .o_window_end(o_window_end), .o_done(o_done), .o_err(o_err),
      .dbg_datareq_row_cnt(dbg_datareq_row_cnt), .dbg_datareq_addr_reg(dbg_datareq_addr_reg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w, h;
      logic [3:0]  k, s;
      logic [31:0] base;
      int          err, reads, lines, wins;
   } vec_t;

   vec_t tbl[10];

   int n_tests = 0, n_fail = 0;
   int cycle = 0, start_cycle, last_beat, done_cyc, err_cyc;
   int n_beats, n_line, n_win, n_done, n_err, rden_viol, hold_viol;
   bit seen_beat, prev_beat;
   logic [31:0] prev_addr;
   logic [31:0] addr_log[256];

   // Outputs are observed on the falling edge, away from the active edge.
   always @(negedge clk) begin
      cycle++;
      if (i_start && start_cycle < 0) start_cycle = cycle;
      if (!prev_beat && seen_beat && o_busy && o_addr !== prev_addr) hold_viol++;
      if (o_rden) begin
         if (i_stall || !i_req) rden_viol++;
         if (n_beats < 256) addr_log[n_beats] = o_addr;
         n_beats++;
         last_beat = cycle;
         seen_beat = 1'b1;
      end
      prev_beat = o_rden;
      prev_addr = o_addr;
      if (o_line_end) n_line++;
      if (o_window_end) n_win++;
      if (o_done) begin n_done++; done_cyc = cycle; end
      if (o_err) begin n_err++; err_cyc = cycle; end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_addr(input int idx, input vec_t v);
      int per_win, win, r;
      per_win = int'(v.k) * int'(v.w);
      win = idx / per_win;
      r   = idx % per_win;
      return v.base + 32'((win * int'(v.s) + r / int'(v.w)) * int'(v.w) + r % int'(v.w));
   endfunction

   task automatic run_frame(input vec_t v, input bit stall_mode, input int abort_beat,
                            input int rst_beat, input int midstart_beat);
      int cyc, tail, r1, r2, r3;
      bit fired;
      n_beats = 0; n_line = 0; n_win = 0; n_done = 0; n_err = 0;
      rden_viol = 0; hold_viol = 0; seen_beat = 0; prev_beat = 0;
      start_cycle = -1; last_beat = -1; done_cyc = -1; err_cyc = -1;
      r1 = $urandom_range(2, 12); r2 = $urandom_range(14, 24); r3 = $urandom_range(26, 36);
      @(posedge clk); #1;
      i_conf_baseaddr    = v.base;
      i_conf_inputshape  = {v.h, v.w};
      i_conf_kernelshape = {28'h0, v.k};
      i_conf_stride      = {28'h0, v.s};
      i_start = 1'b1; i_req = 1'b1; i_stall = 1'b0;
      cyc = 0; tail = -1; fired = 0;
      while (cyc < 3000) begin
         @(posedge clk); #1;
         i_start = 1'b0; i_abort = 1'b0; rst = 1'b0;
         // Latched config must be immune to later changes on the config inputs.
         i_conf_baseaddr = $urandom; i_conf_inputshape = $urandom;
         i_conf_kernelshape = $urandom; i_conf_stride = $urandom;
         if (stall_mode) begin
            i_stall = cyc[0];
            i_req   = !(cyc == r1 || cyc == r2 || cyc == r3);
         end
         if (!fired && abort_beat > 0 && n_beats == abort_beat - 1) begin
            i_abort = 1'b1; fired = 1; tail = 3;
         end
         if (!fired && rst_beat > 0 && n_beats == rst_beat - 1) begin
            rst = 1'b1; fired = 1; tail = 3;
         end
         if (midstart_beat > 0 && n_beats == midstart_beat) i_start = 1'b1;
         if (tail < 0 && (n_done > 0 || n_err > 0)) tail = 3;
         if (tail == 0) break;
         if (tail > 0) tail--;
         cyc++;
      end
      i_start = 1'b0; i_abort = 1'b0; rst = 1'b0; i_stall = 1'b0; i_req = 1'b1;
      check("frame_timeout", cyc >= 3000, 0);
   endtask

   task automatic check_seq(input string name, input vec_t v, input int count);
      int mism = 0;
      for (int i = 0; i < count && i < 256; i++)
         if (addr_log[i] !== exp_addr(i, v)) mism++;
      check(name, mism, 0);
   endtask

   initial begin
      vec_t sc1;
      tbl[0] = '{16'd4, 16'd4, 4'd3, 4'd1, 32'h100,      0, 24, 6, 2};
      tbl[1] = '{16'd2, 16'd5, 4'd3, 4'd2, 32'h0,        0, 12, 6, 2};
      tbl[2] = '{16'd2, 16'd6, 4'd3, 4'd2, 32'h0,        0, 12, 6, 2};
      tbl[3] = '{16'd4, 16'd3, 4'd4, 4'd1, 32'h100,      1,  0, 0, 0};
      tbl[4] = '{16'd4, 16'd4, 4'd0, 4'd1, 32'h100,      1,  0, 0, 0};
      tbl[5] = '{16'd0, 16'd4, 4'd3, 4'd1, 32'h100,      1,  0, 0, 0};
      tbl[6] = '{16'd4, 16'd4, 4'd3, 4'd0, 32'h100,      1,  0, 0, 0};
      tbl[7] = '{16'd3, 16'd5, 4'd2, 4'd1, 32'h20,       0, 24, 8, 4};
      tbl[8] = '{16'd2, 16'd1, 4'd1, 4'd1, 32'hFFFFFFFF, 0,  2, 1, 1};
      tbl[9] = '{16'd3, 16'd3, 4'd3, 4'd5, 32'h40,       0,  9, 3, 1};
      sc1 = tbl[0];

      rst = 1'b1; i_start = 0; i_abort = 0; i_req = 0; i_stall = 0;
      i_conf_baseaddr = '0; i_conf_inputshape = '0; i_conf_kernelshape = '0; i_conf_stride = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {o_addr, o_rden, o_busy, o_line_end, o_window_end, o_done, o_err,
                              dbg_datareq_row_cnt, dbg_datareq_addr_reg}, '0);

      for (int t = 0; t < 10; t++) begin
         run_frame(tbl[t], 0, 0, 0, 0);
         check($sformatf("t%0d_err", t), n_err, tbl[t].err);
         check($sformatf("t%0d_reads", t), n_beats, tbl[t].reads);
         check($sformatf("t%0d_line_end", t), n_line, tbl[t].lines);
         check($sformatf("t%0d_window_end", t), n_win, tbl[t].wins);
         check($sformatf("t%0d_done", t), n_done, (tbl[t].err != 0) ? 0 : 1);
         check($sformatf("t%0d_busy_after", t), o_busy, 0);
         if (tbl[t].err != 0) begin
            check($sformatf("t%0d_err_timing", t), err_cyc - start_cycle, 2);
         end else begin
            check($sformatf("t%0d_done_timing", t), done_cyc - last_beat, 1);
            check_seq($sformatf("t%0d_addr_seq", t), tbl[t], tbl[t].reads);
         end
      end

      run_frame(sc1, 1, 0, 0, 0);
      check("stall_reads", n_beats, 24);
      check("stall_rden_viol", rden_viol, 0);
      check("stall_addr_hold", hold_viol, 0);
      check("stall_done", n_done, 1);
      check_seq("stall_addr_seq", sc1, 24);

      run_frame(sc1, 0, 10, 0, 0);
      check("abort_reads", n_beats, 10);
      check("abort_no_done", n_done, 0);
      check("abort_no_window_end", n_win, 0);
      check("abort_busy_after", o_busy, 0);
      run_frame(sc1, 0, 0, 0, 0);
      check("replay_first_addr", addr_log[0], 32'h100);
      check("replay_reads", n_beats, 24);
      check_seq("replay_addr_seq", sc1, 24);

      run_frame(sc1, 0, 0, 0, 7);
      check("midstart_reads", n_beats, 24);
      check("midstart_done", n_done, 1);
      check_seq("midstart_addr_seq", sc1, 24);

      run_frame(sc1, 0, 0, 5, 0);
      check("rst_reads", n_beats, 5);
      check("rst_no_done", n_done, 0);
      check("rst_outputs", {o_addr, o_rden, o_busy, o_line_end, o_window_end, o_done, o_err,
                            dbg_datareq_row_cnt, dbg_datareq_addr_reg}, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
